// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one spi_top between N requesters, with a watchdog
module spi_req_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_wr,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_din,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   rdata,
  output logic            rerr,
  output logic            timeout,
  output logic            busy,
  output logic            spi_rst,
  output logic            spi_wr,
  output logic [AW-1:0]   spi_addr,
  output logic [DW-1:0]   spi_din,
  input  logic [DW-1:0]   spi_dout,
  input  logic            spi_done,
  input  logic            spi_err
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last, win, pick;
  logic [CW-1:0] cnt;
  logic found, done_q, to_q, rise, expire;
  assign rise    = spi_done && !done_q;
  assign expire  = cnt == CW'(TIMEOUT - 1);
  assign busy    = state != IDLE;
  assign spi_rst = state != BUSY;
  assign gnt     = busy ? {{(N-1){1'b0}}, 1'b1} << win : '0;
  assign ack     = state == RESP ? gnt : '0;
  assign timeout = to_q;
  // search starts just past the previous winner so the last served requester ranks lowest
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[IW'((int'(last) + k) % N)]) begin
        pick  = IW'((int'(last) + k) % N);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? LAUNCH : IDLE;
      LAUNCH:  state_nx = BUSY;
      BUSY:    state_nx = (rise || expire) ? RESP : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= IW'(N - 1);
      win      <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      rdata    <= '0;
      rerr     <= 1'b0;
      spi_wr   <= 1'b0;
      spi_addr <= '0;
      spi_din  <= '0;
    end else begin
      state  <= state_nx;
      done_q <= spi_done;
      cnt    <= state == BUSY ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        win      <= pick;
        spi_wr   <= req_wr[pick];
        spi_addr <= req_addr[int'(pick)*AW +: AW];
        spi_din  <= req_din[int'(pick)*DW +: DW];
      end
      // a done edge on the final watchdog cycle still counts as a normal completion
      if (state == BUSY && rise) begin
        if (!spi_wr) rdata <= spi_dout;
        rerr <= spi_err;
        to_q <= 1'b0;
      end else if (state == BUSY && expire) begin
        rerr <= 1'b1;
        to_q <= 1'b1;
      end
      if (state == RESP) begin
        last <= win;
        to_q <= 1'b0;
      end
    end
  end
endmodule
